ola_synth: RTL and testbench

//  Overlap-add synthesis stage at the output end of the windowed FFT->IFFT chain.

---
 rtl/ola_synth.sv | 156 +++++++++++++++
 tb/tb_ola_synth.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ola_synth.sv
`default_nettype none
// ============================================================================
//  Module   : ola_synth
//  Brief    : 50%-overlap overlap-add synthesis stage after the IFFT. The first
//             half of each frame is summed with the stored second half of the
//             previous frame. Define OLA_SAT_EN to saturate the sum instead of
//             letting it wrap.
//  Revision : 1.0
// ============================================================================
module ola_synth #(
    parameter int N      = 32,
    parameter int HOP    = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof
);

    localparam int IDX_W  = $clog2(N);
    localparam int TAIL_W = $clog2(HOP);

    localparam logic [0:0] ST_HEAD = 1'b0;
    localparam logic [0:0] ST_TAIL = 1'b1;

    localparam logic [IDX_W-1:0]  IDX_ZERO  = '0;
    localparam logic [IDX_W-1:0]  IDX_HEADL = IDX_W'(HOP - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N - 1);
    localparam logic [DATA_W-1:0] DATA_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] DATA_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] tail_q [HOP];
    logic              out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              tail_we;
    logic              tail_clr;
    logic [TAIL_W-1:0] tail_addr;
    logic [DATA_W-1:0] tail_rd;
    logic [DATA_W:0]   sum_full;
    logic [DATA_W-1:0] sum_red;

    // HOP == N/2 is a power of two, so the low index bits address the tail
    // both when reading (idx < HOP) and when writing (idx - HOP).
    assign tail_addr = idx_q[TAIL_W-1:0];
    assign tail_rd   = tail_q[tail_addr];
    assign sum_full  = {in_data[DATA_W-1], in_data} + {tail_rd[DATA_W-1], tail_rd};

`ifdef OLA_SAT_EN
    always_comb begin
        sum_red = sum_full[DATA_W-1:0];
        if (sum_full[DATA_W] != sum_full[DATA_W-1]) begin
            sum_red = sum_full[DATA_W] ? DATA_MIN : DATA_MAX;
        end
    end
`else
    logic unused_sat;
    assign unused_sat = ^{sum_full[DATA_W], DATA_MAX, DATA_MIN};
    assign sum_red    = sum_full[DATA_W-1:0];
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HEAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_HEAD;
        end else if (in_valid) begin
            case (state_q)
                ST_HEAD: if (idx_q == IDX_HEADL) state_d = ST_TAIL;
                ST_TAIL: if (idx_q == IDX_LAST)  state_d = ST_HEAD;
                default: state_d = ST_HEAD;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        idx_d       = idx_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_data_d  = out_data_q;
        tail_we     = 1'b0;
        tail_clr    = 1'b0;
        if (flush) begin
            // Flush wins over a coincident sample, which is dropped.
            idx_d    = IDX_ZERO;
            tail_clr = 1'b1;
        end else if (in_valid) begin
            idx_d = idx_q + 1'b1;
            if (state_q == ST_HEAD) begin
                out_valid_d = 1'b1;
                out_data_d  = sum_red;
                out_sof_d   = (idx_q == IDX_ZERO);
            end else begin
                tail_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < HOP; i++) begin
                tail_q[i] <= '0;
            end
        end else if (tail_clr) begin
            for (int i = 0; i < HOP; i++) begin
                tail_q[i] <= '0;
            end
        end else if (tail_we) begin
            tail_q[tail_addr] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ola_synth.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ola_synth
//  Brief    : Table-driven self-checking bench for ola_synth.
//  Revision : 1.0
// ============================================================================
module tb_ola_synth;

    localparam int DW = 32;

`ifdef OLA_SAT_EN
    localparam logic [DW-1:0] EXP_POS_OVF = 32'h7FFF_FFFF;
    localparam logic [DW-1:0] EXP_NEG_OVF = 32'h8000_0000;
`else
    localparam logic [DW-1:0] EXP_POS_OVF = 32'h8000_0000;
    localparam logic [DW-1:0] EXP_NEG_OVF = 32'h7FFF_FFFF;
`endif

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          f;
        logic          ev;
        logic [DW-1:0] ed;
        logic          es;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sof;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] hold_exp = '0;
    vec_t          vq[$];
    int            seg_a_end, gap_start, gap_end, gap_outs;

    ola_synth #(.N(32), .HOP(16), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic v, input logic [DW-1:0] d, input logic f,
                        input logic ev, input logic [DW-1:0] ed, input logic es);
        vec_t t;
        t.v = v; t.d = d; t.f = f; t.ev = ev; t.ed = ed; t.es = es;
        vq.push_back(t);
    endtask

    // Uniform frame: head value hv gives output ov, tail value tv is stored.
    task automatic push_frame(input logic [DW-1:0] hv, input logic [DW-1:0] ov,
                              input logic [DW-1:0] tv);
        for (int i = 0; i < 16; i++) push(1'b1, hv, 1'b0, 1'b1, ov, i == 0);
        for (int i = 0; i < 16; i++) push(1'b1, tv, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic push_ramp_frame();
        for (int k = 0; k < 32; k++)
            push(1'b1, DW'(k), 1'b0, k < 16, DW'(k), k == 0);
    endtask

    task automatic apply(input vec_t t, input int n);
        @(negedge clk);
        in_valid = t.v;
        in_data  = t.d;
        flush    = t.f;
        @(posedge clk);
        #1;
        if (t.ev) hold_exp = t.ed;
        check($sformatf("v%0d out_valid", n), {31'b0, out_valid}, {31'b0, t.ev});
        check($sformatf("v%0d out_sof", n),   {31'b0, out_sof},   {31'b0, t.es});
        check($sformatf("v%0d out_data", n),  out_data,           hold_exp);
    endtask

    initial begin
        // Segment A: scenarios 1..5 plus the head of the reset-interrupted frame.
        push_ramp_frame();                                   // 1: outputs 0..15
        push_frame(32'd100, 32'd116, 32'd100);               // 2: tail 16..31 -> overwritten below
        for (int i = 0; i < 16; i++) vq[32 + i].ed = DW'(116 + i);
        push(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, '0, 1'b0);     // clear before gap test
        push_ramp_frame();
        gap_start = vq.size();
        for (int i = 0; i < 32; i++) begin                   // 3: gapped frame of 100s
            int g;
            g = $urandom_range(0, 3);
            for (int j = 0; j < g; j++) push(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, 1'b0);
            push(1'b1, 32'd100, 1'b0, i < 16, DW'(116 + i), i == 0);
        end
        gap_end = vq.size();
        push_frame(32'd0, 32'd100, 32'h7FFF_FFFF);           // 4: load positive limit
        push_frame(32'd1, EXP_POS_OVF, 32'h8000_0000);       //    +1 over max
        push_frame(32'hFFFF_FFFF, EXP_NEG_OVF, 32'd0);       //    -1 under min
        for (int i = 0; i < 20; i++)                         // 5: flush at idx 20
            push(1'b1, 32'd3, 1'b0, i < 16, 32'd3, i == 0);
        push(1'b1, 32'd77, 1'b1, 1'b0, '0, 1'b0);
        push_frame(32'd5, 32'd5, 32'd5);
        for (int i = 0; i < 7; i++)                          // 6: HEAD idx 0..6
            push(1'b1, 32'd5, 1'b0, 1'b1, 32'd10, i == 0);
        seg_a_end = vq.size();
        push_ramp_frame();                                   // after reset: as scenario 1
        push_frame(32'd100, 32'd116, 32'd100);
        for (int i = 0; i < 16; i++) vq[seg_a_end + 32 + i].ed = DW'(116 + i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset out_sof",   {31'b0, out_sof},   32'd0);
        check("reset out_data",  out_data,           32'd0);
        @(negedge clk);
        reset = 1'b1;

        gap_outs = 0;
        for (int n = 0; n < seg_a_end; n++) begin
            apply(vq[n], n);
            if (n >= gap_start && n < gap_end && out_valid) gap_outs++;
        end
        check("gap frame output count", gap_outs, 32'd16);

        // Asynchronous reset in the middle of the idx 7 cycle.
        check("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd5;
        #1;
        reset = 1'b0;
        #1;
        hold_exp = '0;
        check("async reset out_valid", {31'b0, out_valid}, 32'd0);
        check("async reset out_data",  out_data,           32'd0);
        check("async reset out_sof",   {31'b0, out_sof},   32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;

        for (int n = seg_a_end; n < vq.size(); n++) apply(vq[n], n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
